// File: rtl/dense_pkg.sv
// dense_pkg: shared types and constants for the dense layer scheduler.
//   state_t      - scheduler FSM state (IDLE/ACCUM/DRAIN/OUT)
//   MAC_RST_HOLD - cycles mac_rst stays high after reset release
package dense_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;

  localparam int MAC_RST_HOLD = 2;
endpackage

// File: rtl/sched_delay_line.sv
// sched_delay_line: fixed-depth shift register for a valid/data pair.
// Only the valid bits are reset, so a reset drops every in-flight beat
// while the data path stays reset-free.
//   clk, rst       - clock, async active-low reset
//   vld, data      - input strobe and payload
//   dly_vld/data   - the same, DEPTH cycles later
module sched_delay_line #(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         vld,
  input  logic [W-1:0] data,
  output logic         dly_vld,
  output logic [W-1:0] dly_data
);
  logic [DEPTH-1:0]        vld_sr;
  logic [DEPTH-1:0][W-1:0] dat_sr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_sr <= '0;
    end else begin
      vld_sr[0] <= vld;
      for (int i = 1; i < DEPTH; i++) vld_sr[i] <= vld_sr[i-1];
    end
  end

  always_ff @(posedge clk) begin
    dat_sr[0] <= data;
    for (int i = 1; i < DEPTH; i++) dat_sr[i] <= dat_sr[i-1];
  end

  assign dly_vld  = vld_sr[DEPTH-1];
  assign dly_data = dat_sr[DEPTH-1];
endmodule

// File: rtl/dense_layer_sched.sv
// dense_layer_sched: feeds NUM_CYC beats per frame into a dense layer,
// drives the weight ROM address, then captures and holds the layer result
// until the downstream consumer takes it.
//   in_vld/in_rdy/in_data    - upstream beat stream
//   w_addr                   - weight ROM address (index of last accepted beat)
//   mac_rst/mac_vld/mac_data - dense layer control and data, ROM-aligned
//   res_vld/res_data         - dense layer result
//   out_vld/out_rdy/out_data - held result to downstream
//   busy                     - FSM not in IDLE
// Optional: define DENSE_SCHED_PERF_EN to add saturating perf_frames and
// perf_stalls counters.
module dense_layer_sched
  import dense_pkg::*;
#(
  parameter int INPUT_SIZE  = 4,
  parameter int BW_IN       = 16,
  parameter int NUM_CYC     = 512,
  parameter int OUTPUT_SIZE = 128,
  parameter int BW_OUT      = 16,
  parameter int ROM_LAT     = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_vld,
  output logic                          in_rdy,
  input  logic [INPUT_SIZE*BW_IN-1:0]   in_data,
  output logic [$clog2(NUM_CYC)-1:0]    w_addr,
  output logic                          mac_rst,
  output logic                          mac_vld,
  output logic [INPUT_SIZE*BW_IN-1:0]   mac_data,
  input  logic                          res_vld,
  input  logic [OUTPUT_SIZE*BW_OUT-1:0] res_data,
  output logic                          out_vld,
  input  logic                          out_rdy,
  output logic [OUTPUT_SIZE*BW_OUT-1:0] out_data,
  output logic                          busy
`ifdef DENSE_SCHED_PERF_EN
  ,
  output logic [31:0]                   perf_frames,
  output logic [31:0]                   perf_stalls
`endif
);
  localparam int AW = $clog2(NUM_CYC);
  localparam int DW = INPUT_SIZE * BW_IN;
  localparam int HW = $clog2(MAC_RST_HOLD + 1);

  state_t        state;
  logic [AW-1:0] cnt;
  logic [HW-1:0] hold;
  logic          accept;
  logic          last;

  // mac_rst stays up while the hold counter drains; inputs are blocked
  // until the dense layer has seen its full reset.
  assign mac_rst = (hold != '0);
  assign in_rdy  = !mac_rst && (state == IDLE || state == ACCUM);
  assign accept  = in_vld && in_rdy;
  assign last    = (cnt == AW'(NUM_CYC - 1));
  assign out_vld = (state == OUT);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      w_addr <= '0;
      hold   <= HW'(MAC_RST_HOLD);
    end else begin
      if (hold != '0) hold <= hold - 1'b1;
      if (accept) begin
        w_addr <= cnt;
        cnt    <= last ? '0 : cnt + 1'b1;
      end
      case (state)
        IDLE:    if (accept) state <= last ? DRAIN : ACCUM;
        ACCUM:   if (accept && last) state <= DRAIN;
        DRAIN:   if (res_vld) state <= OUT;
        OUT:     if (out_rdy) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Result register: loaded only on the DRAIN handshake, so it holds
  // through OUT back-pressure and ignores stray res_vld.
  always_ff @(posedge clk) begin
    if (state == DRAIN && res_vld) out_data <= res_data;
  end

  // The accept strobe takes one cycle to become w_addr and ROM_LAT more to
  // reach the ROM output; delay the beat by the same amount.
  sched_delay_line #(.DEPTH(1 + ROM_LAT), .W(DW)) u_dly (
    .clk      (clk),
    .rst      (rst),
    .vld      (accept),
    .data     (in_data),
    .dly_vld  (mac_vld),
    .dly_data (mac_data)
  );

`ifdef DENSE_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_frames <= '0;
      perf_stalls <= '0;
    end else begin
      if (state == OUT && out_rdy && perf_frames != '1)
        perf_frames <= perf_frames + 1'b1;
      if (state == ACCUM && !in_vld && perf_stalls != '1)
        perf_stalls <= perf_stalls + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_dense_layer_sched.sv
// tb_dense_layer_sched: directed plus randomized stimulus for
// dense_layer_sched, checked every cycle against a frame-level model.
module tb_dense_layer_sched;
  localparam int INPUT_SIZE  = 4;
  localparam int BW_IN       = 16;
  localparam int NUM_CYC     = 8;
  localparam int OUTPUT_SIZE = 4;
  localparam int BW_OUT      = 16;
  localparam int ROM_LAT     = 1;
  localparam int DW = INPUT_SIZE * BW_IN;
  localparam int OW = OUTPUT_SIZE * BW_OUT;
  localparam int AW = $clog2(NUM_CYC);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_vld = 1'b0;
  logic          in_rdy;
  logic [DW-1:0] in_data = '0;
  logic [AW-1:0] w_addr;
  logic          mac_rst;
  logic          mac_vld;
  logic [DW-1:0] mac_data;
  logic          res_vld = 1'b0;
  logic [OW-1:0] res_data = '0;
  logic          out_vld;
  logic          out_rdy = 1'b0;
  logic [OW-1:0] out_data;
  logic          busy;
`ifdef DENSE_SCHED_PERF_EN
  logic [31:0]   perf_frames;
  logic [31:0]   perf_stalls;
`endif

  dense_layer_sched #(
    .INPUT_SIZE(INPUT_SIZE), .BW_IN(BW_IN), .NUM_CYC(NUM_CYC),
    .OUTPUT_SIZE(OUTPUT_SIZE), .BW_OUT(BW_OUT), .ROM_LAT(ROM_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data),
    .w_addr(w_addr), .mac_rst(mac_rst), .mac_vld(mac_vld), .mac_data(mac_data),
    .res_vld(res_vld), .res_data(res_data),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data),
    .busy(busy)
`ifdef DENSE_SCHED_PERF_EN
    , .perf_frames(perf_frames), .perf_stalls(perf_stalls)
`endif
  );

  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: frame-level view of the scheduler.
  //   m_mode 0 = collecting beats, 1 = waiting for result, 2 = offering result
  int            m_hold, m_mode, m_beats, m_waddr;
  logic [OW-1:0] m_out;
  logic [31:0]   m_frames, m_stalls;
  int            cyc = 0;
  int            rst_mark = 0;
  bit            hist_acc [0:4095];
  logic [DW-1:0] hist_dat [0:4095];
  int            mv_seen, ov_seen;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; in_vld = 1'b0; res_vld = 1'b0; out_rdy = 1'b0;
    #1;
    m_hold = 2; m_mode = 0; m_beats = 0; m_waddr = 0;
    m_frames = '0; m_stalls = '0;
    chk("rst_mac_rst", mac_rst, 1);
    chk("rst_in_rdy", in_rdy, 0);
    chk("rst_mac_vld", mac_vld, 0);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_w_addr", w_addr, 0);
`ifdef DENSE_SCHED_PERF_EN
    chk("rst_perf_frames", perf_frames, 0);
    chk("rst_perf_stalls", perf_stalls, 0);
`endif
    @(posedge clk);
    #2 rst = 1'b1;
    rst_mark = cyc;
  endtask

  task automatic step(input logic iv, input logic [DW-1:0] id, input logic rv,
                      input logic [OW-1:0] rd, input logic ordy);
    bit acc, ev, rdy;
    int t2;
    @(negedge clk);
    in_vld = iv; in_data = id; res_vld = rv; res_data = rd; out_rdy = ordy;
    #1;
    t2  = cyc - 1 - ROM_LAT;
    ev  = (t2 >= rst_mark) && hist_acc[t2 & 4095];
    rdy = (m_hold == 0) && (m_mode == 0);
    chk("mac_rst", mac_rst, m_hold != 0);
    chk("in_rdy", in_rdy, rdy);
    chk("busy", busy, (m_mode != 0) || (m_beats != 0));
    chk("w_addr", w_addr, m_waddr);
    chk("mac_vld", mac_vld, ev);
    if (ev) chk("mac_data", mac_data, hist_dat[t2 & 4095]);
    chk("out_vld", out_vld, m_mode == 2);
    if (m_mode == 2) chk("out_data", out_data, m_out);
`ifdef DENSE_SCHED_PERF_EN
    chk("perf_frames", perf_frames, m_frames);
    chk("perf_stalls", perf_stalls, m_stalls);
`endif
    if (mac_vld) mv_seen++;
    if (out_vld) ov_seen++;
    acc = iv && rdy;
    hist_acc[cyc & 4095] = acc;
    hist_dat[cyc & 4095] = id;
    if (m_mode == 2 && ordy && m_frames != 32'hFFFF_FFFF) m_frames++;
    if (m_mode == 0 && m_beats != 0 && !iv && m_stalls != 32'hFFFF_FFFF) m_stalls++;
    if (m_hold != 0) m_hold--;
    case (m_mode)
      0: if (acc) begin
           m_waddr = m_beats;
           m_beats++;
           if (m_beats == NUM_CYC) begin m_beats = 0; m_mode = 1; end
         end
      1: if (rv) begin m_out = rd; m_mode = 2; end
      default: if (ordy) m_mode = 0;
    endcase
    cyc++;
  endtask

  function automatic logic [DW-1:0] rnd_dw();
    return {$urandom, $urandom};
  endfunction
  function automatic logic [OW-1:0] rnd_ow();
    return {$urandom, $urandom};
  endfunction

  initial begin
    logic [13:0] stall_pat;
    stall_pat = 14'b11_000_111_000_111;

    // Reset release: mac_rst two cycles, in_rdy from the third.
    do_reset();
    for (int i = 0; i < 3; i++) step(0, '0, 0, '0, 0);

    // Eight back-to-back beats, then extra offers that must be refused.
    mv_seen = 0;
    for (int i = 0; i < 10; i++) step(1, rnd_dw(), 0, '0, 0);
    chk("b2b_mac_pulses", mv_seen, 8);
    step(0, '0, 1, {4{16'hA5A5}}, 0);
    ov_seen = 0;
    // Held result under back-pressure; stray res_vld must be ignored.
    for (int i = 0; i < 10; i++) step(0, '0, 1, rnd_ow(), 0);
    chk("hold_out_vld_cycles", ov_seen, 10);
    step(0, '0, 0, '0, 1);
    step(0, '0, 0, '0, 0);

    // Upstream stalls after beats 2 and 5 for three cycles each.
    mv_seen = 0;
    for (int i = 13; i >= 0; i--) step(stall_pat[i], rnd_dw(), 0, '0, 0);
    step(0, '0, 0, '0, 0);
    step(0, '0, 0, '0, 0);
    chk("stall_mac_pulses", mv_seen, 8);
    step(0, '0, 1, rnd_ow(), 1);
    step(0, '0, 0, '0, 1);

    // Reset at beat 4: partial frame and in-flight beats discarded.
    for (int i = 0; i < 4; i++) step(1, rnd_dw(), 0, '0, 0);
    do_reset();
    mv_seen = 0;
    for (int i = 0; i < 2; i++) step(0, '0, 0, '0, 0);
    chk("post_rst_no_stale_mac", mv_seen, 0);
    for (int i = 0; i < 12; i++) step(1, rnd_dw(), 0, '0, 0);
    step(0, '0, 1, rnd_ow(), 1);
    step(0, '0, 0, '0, 1);

`ifdef DENSE_SCHED_PERF_EN
    // Three frames with five ACCUM stall cycles in total.
    do_reset();
    for (int i = 0; i < 2; i++) step(0, '0, 0, '0, 0);
    for (int f = 0; f < 3; f++) begin
      for (int b = 0; b < 8; b++) begin
        if (f == 0 && b == 1) for (int s = 0; s < 5; s++) step(0, '0, 0, '0, 0);
        step(1, rnd_dw(), 0, '0, 0);
      end
      step(0, '0, 1, rnd_ow(), 1);
      step(0, '0, 0, '0, 1);
    end
    step(0, '0, 0, '0, 0);
    chk("perf_frames_3", perf_frames, 3);
    chk("perf_stalls_5", perf_stalls, 5);
`endif

    // Randomized traffic with back-pressure and stray results.
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) != 0, rnd_dw(), $urandom_range(0, 3) == 0,
           rnd_ow(), $urandom_range(0, 1) == 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
